// File: rtl/sp_ram_banked.sv
// sp_ram_banked: multi-bank single-port SRAM subsystem.
//
// Built from NUM_BANKS sky130_sram_2kbyte_1rw1r_32x512_8 macros (512 x 32,
// byte-masked), each covering 2 KiB of a contiguous byte address space.
// Only port 0 of each macro is used. Port 1 is tied off.
//
// Optional build macro: SP_RAM_OUT_REG_EN
//   defined   - adds an output register on rvalid/err/rdata (latency 2)
//   undefined - response presented one cycle after accept (latency 1)
//
// Ports:
//   clk          system clock, drives clk0 of every macro
//   rst_i        asynchronous active-high reset
//   req_i        access request
//   gnt_o        request accepted this cycle (combinational)
//   addr_i       byte address, bits [1:0] ignored
//   we_i         1 = write, 0 = read
//   be_i         byte enables for writes
//   wdata_i      write data
//   bypass_en_i  drop writes (still acknowledged), reads proceed
//   rvalid_o     response valid
//   rdata_o      read data (zero for writes and errors)
//   err_o        out-of-range error, valid with rvalid_o
//   init_i       start zero-initialisation of the whole RAM
//   busy_o       zero-initialisation in progress

// Behavioural stand-in for the sky130 2 KiB dual-port macro.
// Port 0 is read/write, port 1 is read-only. Outputs update on the clock
// edge that samples an active chip select.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [8:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [512];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

module sp_ram_banked #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  input  logic                  bypass_en_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic                  init_i,
  output logic                  busy_o
);

  localparam int RAM_SIZE = NUM_BANKS * 2048;
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [8:0]  cnt, cnt_next;

  logic [8:0]        word;
  logic [BANK_W-1:0] bank;
  logic              in_range;
  logic              accept;
  logic              clearing;

  assign word     = addr_i[10:2];
  assign in_range = (addr_i < ADDR_WIDTH'(RAM_SIZE));

  generate
    if (NUM_BANKS > 1) begin : g_bank_sel
      assign bank = addr_i[11 +: BANK_W];
    end else begin : g_bank_one
      assign bank = '0;
    end
  endgenerate

  // The reset term keeps gnt_o low while the block is held in reset.
  assign gnt_o    = req_i & (state == IDLE) & ~init_i & ~rst_i;
  assign accept   = gnt_o;
  assign clearing = (state == CLEAR);
  assign busy_o   = clearing;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (init_i) state_next = CLEAR;
      end
      CLEAR: begin
        cnt_next = cnt + 9'd1;
        if (cnt == 9'd511) state_next = DONE;
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Macro port 0 drive. Address, data, mask and write strobe are shared by
  // all banks; only chip select is per bank. During a clear every bank is
  // written with zero at the sweep address.
  // ---------------------------------------------------------------------
  logic [NUM_BANKS-1:0] mem_csb;
  logic                 mem_web;
  logic [3:0]           mem_wmask;
  logic [8:0]           mem_addr;
  logic [31:0]          mem_din;

  always_comb begin
    mem_csb   = '1;
    mem_web   = ~(we_i & ~bypass_en_i);
    mem_wmask = be_i;
    mem_addr  = word;
    mem_din   = wdata_i;
    if (clearing) begin
      mem_csb   = '0;
      mem_web   = 1'b0;
      mem_wmask = 4'hF;
      mem_addr  = cnt;
      mem_din   = '0;
    end else if (accept && in_range) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank == BANK_W'(b)) mem_csb[b] = 1'b0;
      end
    end
  end

  logic [31:0] dout [NUM_BANKS];
  logic [31:0] dout1_unused [NUM_BANKS];

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      sky130_sram_2kbyte_1rw1r_32x512_8 u_sram (
        .clk0   (clk),
        .csb0   (mem_csb[g]),
        .web0   (mem_web),
        .wmask0 (mem_wmask),
        .addr0  (mem_addr),
        .din0   (mem_din),
        .dout0  (dout[g]),
        .clk1   (1'b0),
        .csb1   (1'b1),
        .addr1  (9'd0),
        .dout1  (dout1_unused[g])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Response stage. pend_zero forces rdata to zero for writes and errors so
  // the stale macro output never leaks out.
  // ---------------------------------------------------------------------
  logic              pend_v;
  logic              pend_err;
  logic              pend_zero;
  logic [BANK_W-1:0] pend_bank;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pend_v    <= 1'b0;
      pend_err  <= 1'b0;
      pend_zero <= 1'b0;
      pend_bank <= '0;
    end else begin
      pend_v    <= accept;
      pend_err  <= accept & ~in_range;
      pend_zero <= accept & (we_i | ~in_range);
      if (accept) pend_bank <= bank;
    end
  end

  logic [31:0] resp_data;
  assign resp_data = (pend_v && !pend_zero) ? dout[pend_bank] : '0;

`ifdef SP_RAM_OUT_REG_EN
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pend_v;
      err_q    <= pend_err;
      rdata_q  <= resp_data;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
`else
  assign rvalid_o = pend_v;
  assign err_o    = pend_err;
  assign rdata_o  = resp_data;
`endif

endmodule

// File: tb/tb_sp_ram_banked.sv
module tb_sp_ram_banked;

  localparam int NB    = 4;
  localparam int RS    = NB * 2048;
  localparam int WORDS = RS / 4;
`ifdef SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        bypass_en_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        init_i;
  logic        busy_o;

  sp_ram_banked #(.NUM_BANKS(NB), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .bypass_en_i (bypass_en_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_i      (init_i),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: word-addressed memory, expected-response pipeline of
  // depth LAT, and a cycle budget for the clear sweep.
  // ---------------------------------------------------------------------
  logic [31:0] mem_m [WORDS];
  bit          mem_valid = 1'b0;
  bit          p_v   [2];
  bit          p_e   [2];
  bit          p_chk [2];
  logic [31:0] p_d   [2];
  int          clear_left = 0;
  bit          done_ph = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      p_v[k] = 0; p_e[k] = 0; p_chk[k] = 0; p_d[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst_i) begin
        chk1("rst_rvalid", rvalid_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_gnt", gnt_o, 1'b0);
        chk32("rst_rdata", rdata_o, 32'h0);
        if (clear_left > 0) mem_valid = 1'b0;
        for (int k = 0; k < 2; k++) p_v[k] = 0;
        clear_left = 0;
        done_ph = 1'b0;
      end else begin
        bit idle, g;
        chk1("rvalid", rvalid_o, p_v[LAT-1]);
        if (p_v[LAT-1]) begin
          chk1("err", err_o, p_e[LAT-1]);
          if (p_chk[LAT-1]) chk32("rdata", rdata_o, p_d[LAT-1]);
        end
        idle = (clear_left == 0) && !done_ph;
        g = req_i && idle && !init_i;
        chk1("gnt", gnt_o, g);
        chk1("busy", busy_o, clear_left > 0);

        p_v[1] = p_v[0]; p_e[1] = p_e[0]; p_chk[1] = p_chk[0]; p_d[1] = p_d[0];
        p_v[0] = g; p_e[0] = 0; p_chk[0] = 1; p_d[0] = '0;
        if (g) begin
          if (addr_i >= RS) begin
            p_e[0] = 1;
          end else begin
            int idx;
            idx = int'(addr_i >> 2);
            if (we_i) begin
              if (!bypass_en_i)
                for (int b = 0; b < 4; b++)
                  if (be_i[b]) mem_m[idx][8*b +: 8] = wdata_i[8*b +: 8];
            end else begin
              p_d[0]   = mem_m[idx];
              p_chk[0] = mem_valid;
            end
          end
        end

        if (clear_left > 0) begin
          clear_left--;
          if (clear_left == 0) begin
            done_ph = 1'b1;
            for (int w = 0; w < WORDS; w++) mem_m[w] = '0;
            mem_valid = 1'b1;
          end
        end else if (done_ph) begin
          done_ph = 1'b0;
        end else if (init_i) begin
          clear_left = 512;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------
  task automatic idle_in();
    req_i = 0; we_i = 0; addr_i = '0; be_i = '0; wdata_i = '0;
    bypass_en_i = 0; init_i = 0;
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input bit byp);
    @(posedge clk); #2;
    req_i = 1; we_i = we; addr_i = a; be_i = be; wdata_i = d; bypass_en_i = byp;
    init_i = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                    input bit byp);
    issue(1'b1, a, be, d, byp);
    @(posedge clk); #2;
    idle_in();
  endtask

  task automatic read_lit(input string name, input logic [31:0] a,
                          input logic [31:0] exp_d, input bit exp_e);
    issue(1'b0, a, 4'hF, '0, 1'b0);
    @(posedge clk); #2;
    idle_in();
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk1({name, "_rvalid"}, rvalid_o, 1'b1);
    chk32(name, rdata_o, exp_d);
    chk1({name, "_err"}, err_o, exp_e);
  endtask

  task automatic run_init(output int n);
    @(posedge clk); #2;
    idle_in();
    init_i = 1; req_i = 1;
    @(negedge clk);
    chk1("init_gnt", gnt_o, 1'b0);
    @(posedge clk); #2;
    idle_in();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
    end
  endtask

  initial begin
    int n;
    idle_in();
    rst_i = 1;
    repeat (3) @(posedge clk);
    #2 rst_i = 0;

    run_init(n);
    chk32("first_clear_len", n, 512);

    // Basic write/read across a bank boundary.
    wr(32'h0000_0804, 4'hF, 32'hDEADBEEF, 1'b0);
    read_lit("rd_804", 32'h0000_0804, 32'hDEADBEEF, 1'b0);

    // Byte-masked merge.
    wr(32'h0000_0010, 4'hF, 32'h11223344, 1'b0);
    wr(32'h0000_0010, 4'b0101, 32'hAABBCCDD, 1'b0);
    read_lit("rd_mask", 32'h0000_0010, 32'h11BB33DD, 1'b0);
    chk32("model_pin_mask", mem_m[4], 32'h11BB33DD);

    // Bypassed write leaves memory alone.
    wr(32'h0000_0010, 4'hF, 32'hFFFFFFFF, 1'b1);
    read_lit("rd_bypass", 32'h0000_0010, 32'h11BB33DD, 1'b0);

    // Zero byte-enable write leaves memory alone.
    wr(32'h0000_0804, 4'h0, 32'h0, 1'b0);
    read_lit("rd_be0", 32'h0000_0804, 32'hDEADBEEF, 1'b0);

    // Out-of-range read followed back-to-back by an in-range read.
    issue(1'b0, 32'h0000_2000, 4'hF, '0, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #2;
      if (k == 1) begin
        req_i = 1; we_i = 0; addr_i = 32'h0000_0804; be_i = 4'hF;
      end else begin
        idle_in();
      end
      @(negedge clk);
      if (k == LAT) begin
        chk1("oor_rvalid", rvalid_o, 1'b1);
        chk1("oor_err", err_o, 1'b1);
        chk32("oor_rdata", rdata_o, 32'h0);
      end
      if (k == LAT + 1) begin
        chk1("b2b_rvalid", rvalid_o, 1'b1);
        chk1("b2b_err", err_o, 1'b0);
        chk32("b2b_rdata", rdata_o, 32'hDEADBEEF);
      end
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      @(posedge clk); #2;
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom();
        if (a < RS) a = a + RS;
      end else begin
        int w;
        w = int'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) w = w + 496;
        w = w + int'($urandom_range(0, NB - 1)) * 512;
        a = (32'(w) << 2) | 32'($urandom_range(0, 3));
      end
      req_i       = ($urandom_range(0, 3) != 0);
      we_i        = $urandom_range(0, 1) == 1;
      addr_i      = a;
      be_i        = 4'($urandom_range(0, 15));
      wdata_i     = $urandom();
      bypass_en_i = ($urandom_range(0, 7) == 0);
      init_i      = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #2;
    idle_in();
    repeat (600) @(posedge clk);

    // Fill corners, clear, and confirm they read back as zero.
    wr(32'h0000_0000, 4'hF, 32'h0BADF00D, 1'b0);
    wr(32'h0000_07FC, 4'hF, 32'h12345678, 1'b0);
    wr(32'h0000_1FFC, 4'hF, 32'hCAFEBABE, 1'b0);
    read_lit("pre_clr_1ffc", 32'h0000_1FFC, 32'hCAFEBABE, 1'b0);
    run_init(n);
    chk32("clear_len", n, 512);
    read_lit("clr_0", 32'h0000_0000, 32'h0, 1'b0);
    read_lit("clr_7fc", 32'h0000_07FC, 32'h0, 1'b0);
    read_lit("clr_1ffc", 32'h0000_1FFC, 32'h0, 1'b0);

    // Reset in the middle of a clear.
    @(posedge clk); #2;
    init_i = 1;
    @(posedge clk); #2;
    idle_in();
    repeat (100) @(posedge clk);
    #2 rst_i = 1;
    @(negedge clk);
    chk1("abort_busy", busy_o, 1'b0);
    chk1("abort_rvalid", rvalid_o, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_i = 0;
    req_i = 1; we_i = 0; addr_i = 32'h0000_0804; be_i = 4'hF;
    @(negedge clk);
    chk1("abort_gnt", gnt_o, 1'b1);
    chk1("abort_no_rvalid", rvalid_o, 1'b0);
    @(posedge clk); #2;
    idle_in();
    repeat (3) @(posedge clk);

    run_init(n);
    chk32("reclear_len", n, 512);
    read_lit("reclr_804", 32'h0000_0804, 32'h0, 1'b0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
